// File: rtl/spart_rx.sv
// SPART receive path: 16x-oversampled 8N1 receiver with programmable baud divisor
// and a one-deep receive buffer carrying rda / framing_err / overrun status.
module spart_rx #(
   parameter logic [15:0] DEFAULT_DIV = 16'd650,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   input  logic       brg_ld_lo,
   input  logic       brg_ld_hi,
   input  logic [7:0] brg_din,
   input  logic       rd_ack,
   output logic [7:0] rx_data,
   output logic       rda,
   output logic       framing_err,
   output logic       overrun
);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxs;
   logic [15:0]            db_q;
   logic [15:0]            tcnt_q;
   logic                   tick;
   state_e                 state_q, state_d;
   logic [3:0]             scnt_q, scnt_d;
   logic [2:0]             bcnt_q, bcnt_d;
   logic [7:0]             shreg_q, shreg_d;
   logic                   done;

   // rxd is asynchronous; idle-high reset avoids a spurious start after reset
   always_ff @(posedge clk) begin
      if (rst) sync_q <= '1;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
   end
   assign rxs = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         db_q <= DEFAULT_DIV;
      end else begin
         if (brg_ld_lo) db_q[7:0]  <= brg_din;
         if (brg_ld_hi) db_q[15:8] <= brg_din;
      end
   end

   // Divisor changes are picked up only at reload, so a running period is never cut short
   assign tick = (tcnt_q == 16'd0);
   always_ff @(posedge clk) begin
      if (rst)       tcnt_q <= DEFAULT_DIV;
      else if (tick) tcnt_q <= db_q;
      else           tcnt_q <= tcnt_q - 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         scnt_q  <= '0;
         bcnt_q  <= '0;
         shreg_q <= '0;
      end else begin
         state_q <= state_d;
         scnt_q  <= scnt_d;
         bcnt_q  <= bcnt_d;
         shreg_q <= shreg_d;
      end
   end

   always_comb begin
      state_d = state_q;
      scnt_d  = scnt_q;
      bcnt_d  = bcnt_q;
      shreg_d = shreg_q;
      done    = 1'b0;
      if (tick) begin
         unique case (state_q)
            StIdle: begin
               if (!rxs) begin
                  state_d = StStart;
                  scnt_d  = '0;
               end
            end
            StStart: begin
               if (scnt_q == 4'd7) begin
                  if (!rxs) begin
                     state_d = StData;
                     scnt_d  = '0;
                     bcnt_d  = '0;
                  end else begin
                     state_d = StIdle;
                  end
               end else begin
                  scnt_d = scnt_q + 4'd1;
               end
            end
            StData: begin
               // scnt wraps 15->0, so the next sample lands 16 ticks later
               scnt_d = scnt_q + 4'd1;
               if (scnt_q == 4'd15) begin
                  shreg_d = {rxs, shreg_q[7:1]};
                  bcnt_d  = bcnt_q + 3'd1;
                  if (bcnt_q == 3'd7) state_d = StStop;
               end
            end
            StStop: begin
               scnt_d = scnt_q + 4'd1;
               if (scnt_q == 4'd15) begin
                  done    = 1'b1;
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // A read in the completion cycle frees the buffer for the arriving byte
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data     <= 8'h00;
         rda         <= 1'b0;
         framing_err <= 1'b0;
         overrun     <= 1'b0;
      end else if (done && (!rda || rd_ack)) begin
         rx_data     <= shreg_q;
         rda         <= 1'b1;
         framing_err <= ~rxs;
         overrun     <= 1'b0;
      end else if (done) begin
         overrun     <= 1'b1;
      end else if (rd_ack) begin
         rda         <= 1'b0;
         framing_err <= 1'b0;
         overrun     <= 1'b0;
      end
   end

endmodule

// File: tb/tb_spart_rx.sv
// Bench for spart_rx: table-driven frames, hand-built corner sequences and random
// frames checked against a byte-level buffer model.
module tb_spart_rx;

   localparam logic [15:0] TB_DIV   = 16'd49;
   localparam int          BIT_DEF  = (int'(TB_DIV) + 1) * 16;
   localparam int          BIT_FAST = 64;

   logic       clk, rst, rxd, brg_ld_lo, brg_ld_hi, rd_ack;
   logic [7:0] brg_din, rx_data;
   logic       rda, framing_err, overrun;
   int         cyc;
   int         n_checks, n_pass;

   typedef struct {
      logic       ack;
      logic [7:0] data;
      logic       stop;
      logic [7:0] exp_data;
      logic       exp_rda;
      logic       exp_fe;
      logic       exp_ovr;
   } vec_t;

   vec_t tbl[6];

   spart_rx #(
      .DEFAULT_DIV(TB_DIV),
      .SYNC_STAGES(2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rxd        (rxd),
      .brg_ld_lo  (brg_ld_lo),
      .brg_ld_hi  (brg_ld_hi),
      .brg_din    (brg_din),
      .rd_ack     (rd_ack),
      .rx_data    (rx_data),
      .rda        (rda),
      .framing_err(framing_err),
      .overrun    (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // cyc == k in the cycle after the k-th edge since the last reset edge
   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %02h required %02h", name, got, exp);
   endtask

   task automatic chk_all(input string tag, input logic [7:0] d, input logic r,
                          input logic f, input logic o);
      chk({tag, " rx_data"}, rx_data, d);
      chk({tag, " rda"}, {7'd0, rda}, {7'd0, r});
      chk({tag, " framing_err"}, {7'd0, framing_err}, {7'd0, f});
      chk({tag, " overrun"}, {7'd0, overrun}, {7'd0, o});
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input int bclk);
      logic [9:0] bits;
      bits = {stop, d, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rxd = bits[i];
         repeat (bclk) @(negedge clk);
      end
      rxd = 1'b1;
   endtask

   task automatic pulse_ack();
      rd_ack = 1'b1;
      @(negedge clk);
      rd_ack = 1'b0;
   endtask

   task automatic load_div(input logic [15:0] v);
      brg_din   = v[7:0];
      brg_ld_lo = 1'b1;
      @(negedge clk);
      brg_ld_lo = 1'b0;
      brg_din   = v[15:8];
      brg_ld_hi = 1'b1;
      @(negedge clk);
      brg_ld_hi = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   // Ticks fall on cycles TB_DIV + 4k once DB=3; start so rxs falls exactly on a tick
   task automatic align_start();
      for (int k = 0; k < 8 && ((cyc + 2 - int'(TB_DIV)) % 4) != 0; k++) @(negedge clk);
   endtask

   logic [7:0] m_data;
   logic       m_rda, m_fe, m_ovr;
   logic [7:0] rd;
   logic       rs, ra;
   int         c1;

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      rxd       = 1'b1;
      brg_ld_lo = 1'b0;
      brg_ld_hi = 1'b0;
      brg_din   = 8'h00;
      rd_ack    = 1'b0;
      rst       = 1'b0;

      tbl[0] = '{1'b1, 8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 8'h3C, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0};
      tbl[2] = '{1'b0, 8'h77, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1};
      tbl[3] = '{1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
      tbl[4] = '{1'b1, 8'hFF, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0};
      tbl[5] = '{1'b0, 8'h81, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1};

      @(negedge clk);
      do_reset();
      chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);

      // Reset-loaded divisor
      send_frame(8'h55, 1'b1, BIT_DEF);
      idle(200);
      chk_all("default_div", 8'h55, 1'b1, 1'b0, 1'b0);
      pulse_ack();
      chk("default_div ack rda", {7'd0, rda}, 8'd0);
      chk("default_div ack rx_data", rx_data, 8'h55);

      load_div(16'd3);
      idle(100);

      for (int i = 0; i < 6; i++) begin
         if (tbl[i].ack) pulse_ack();
         idle(4);
         send_frame(tbl[i].data, tbl[i].stop, BIT_FAST);
         idle(130);
         chk_all($sformatf("vec%0d", i), tbl[i].exp_data, tbl[i].exp_rda,
                 tbl[i].exp_fe, tbl[i].exp_ovr);
      end

      pulse_ack();
      chk_all("ack clears", 8'hFF, 1'b0, 1'b0, 1'b0);
      pulse_ack();
      chk_all("ack idle", 8'hFF, 1'b0, 1'b0, 1'b0);

      // Short low pulse is a false start
      rxd = 1'b0;
      idle(16);
      rxd = 1'b1;
      idle(2000);
      chk_all("glitch", 8'hFF, 1'b0, 1'b0, 1'b0);
      send_frame(8'h5A, 1'b1, BIT_FAST);
      idle(130);
      chk_all("after glitch", 8'h5A, 1'b1, 1'b0, 1'b0);

      pulse_ack();
      m_data = 8'h5A;
      m_rda  = 1'b0;
      m_fe   = 1'b0;
      m_ovr  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         rd = 8'($urandom);
         rs = ($urandom_range(0, 3) != 0);
         ra = 1'($urandom);
         if (ra) begin
            pulse_ack();
            m_rda = 1'b0;
            m_fe  = 1'b0;
            m_ovr = 1'b0;
         end
         idle(4);
         send_frame(rd, rs, BIT_FAST);
         if (!m_rda) begin
            m_data = rd;
            m_rda  = 1'b1;
            m_fe   = ~rs;
            m_ovr  = 1'b0;
         end else begin
            m_ovr = 1'b1;
         end
         idle(128 + int'($urandom_range(0, 50)));
         chk_all($sformatf("rand%0d", i), m_data, m_rda, m_fe, m_ovr);
      end

      // Back-to-back frames, tick-aligned so the completion cycle is known
      do_reset();
      load_div(16'd3);
      idle(100);
      align_start();
      send_frame(8'h11, 1'b1, BIT_FAST);
      send_frame(8'h22, 1'b1, BIT_FAST);
      idle(20);
      chk_all("overrun", 8'h11, 1'b1, 1'b0, 1'b1);
      pulse_ack();
      chk_all("overrun ack", 8'h11, 1'b0, 1'b0, 1'b0);

      idle(50);
      align_start();
      send_frame(8'h11, 1'b1, BIT_FAST);
      c1 = cyc;
      fork
         send_frame(8'h22, 1'b1, BIT_FAST);
         begin
            for (int k = 0; k < 700 && cyc != c1 + 610; k++) @(negedge clk);
            pulse_ack();
         end
      join
      idle(20);
      chk_all("ack at completion", 8'h22, 1'b1, 1'b0, 1'b0);

      // Reset in the middle of a frame
      rxd = 1'b0;
      idle(BIT_FAST);
      rxd = 1'b1;
      idle(BIT_FAST);
      rxd = 1'b0;
      idle(100);
      rst = 1'b1;
      @(negedge clk);
      chk_all("mid-frame reset", 8'h00, 1'b0, 1'b0, 1'b0);
      rxd = 1'b1;
      rst = 1'b0;
      load_div(16'd3);
      idle(100);
      chk("post reset rda", {7'd0, rda}, 8'd0);
      send_frame(8'h55, 1'b1, BIT_FAST);
      idle(130);
      chk_all("post reset frame", 8'h55, 1'b1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
